// File: rtl/alu_regfile_pc_if.sv
// Sequencer-facing bus of the 8-bit execution datapath (alu_regfile_pc).
// Handshake: exec is the valid, !busy is the ready; an op transfers on the rising edge where exec=1 and busy=0.
interface alu_regfile_pc_if;
  logic       exec;
  logic       load;
  logic [2:0] ra;
  logic [2:0] rb;
  logic [2:0] rc;
  logic [3:0] fsl;
  logic [7:0] ld_data;
  logic       hold;
  logic       jump;
  logic [7:0] jump_line;
  logic [7:0] rd_a;
  logic [7:0] rd_b;
  logic       busy;
  logic       done;
  logic [15:0] result;
  logic [3:0] sreg;
  logic [7:0] pc;
  logic [1:0] dbgState;

  modport master (
    output exec, load, ra, rb, rc, fsl, ld_data, hold, jump, jump_line,
    input  rd_a, rd_b, busy, done, result, sreg, pc, dbgState
  );

  modport slave (
    input  exec, load, ra, rb, rc, fsl, ld_data, hold, jump, jump_line,
    output rd_a, rd_b, busy, done, result, sreg, pc, dbgState
  );
endinterface

// File: rtl/alu_regfile_pc.sv
// Execution datapath: 8x8 register file, 16-function ALU with {V,S,C,Z} status, 8-bit PC.
// Optional macro MUL_HIGH_WB_EN: MUL also writes its high byte to R[(rc+1) mod 8].
module alu_regfile_pc (
  input logic             clk,
  input logic             rst_n,
  alu_regfile_pc_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_OPLATCH = 2'd1,
    S_WRBACK  = 2'd2
  } stateT;

  localparam logic [3:0] FSL_ADD = 4'h0, FSL_SUB = 4'h1, FSL_MUL = 4'h2, FSL_AND = 4'h3;
  localparam logic [3:0] FSL_OR  = 4'h4, FSL_XOR = 4'h5, FSL_NOT = 4'h6, FSL_SHL = 4'h7;
  localparam logic [3:0] FSL_SHR = 4'h8, FSL_ROL = 4'h9, FSL_ROR = 4'hA, FSL_INC = 4'hB;
  localparam logic [3:0] FSL_DEC = 4'hC, FSL_PASS = 4'hD, FSL_NEG = 4'hE, FSL_CMP = 4'hF;

  stateT       state, stateNext;
  logic        isBusy, isWb, accept;
  logic [7:0]  regFile [8];
  logic [7:0]  regNext [8];
  logic [2:0]  raQ, rbQ, rcQ;
  logic [3:0]  fslQ;
  logic [7:0]  opA, opB;
  logic [8:0]  sum9;
  logic [15:0] prod;
  logic [7:0]  aluLow, aluHigh;
  logic        aluC, aluV;
  logic [15:0] resultQ;
  logic [3:0]  sregQ;
  logic [7:0]  pcQ;

  assign accept = bus.exec && !isBusy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= stateNext;
  end

  // The writeback cycle is not busy, so a new op can be accepted back-to-back.
  always_comb begin
    stateNext = S_IDLE;
    case (state)
      S_IDLE:    stateNext = accept ? S_OPLATCH : S_IDLE;
      S_OPLATCH: stateNext = S_WRBACK;
      S_WRBACK:  stateNext = accept ? S_OPLATCH : S_IDLE;
      default:   stateNext = S_IDLE;
    endcase
  end

  always_comb begin
    isBusy = 1'b0;
    isWb   = 1'b0;
    case (state)
      S_OPLATCH: isBusy = 1'b1;
      S_WRBACK:  isWb   = 1'b1;
      default:   ;
    endcase
  end

  always_comb begin
    aluLow  = 8'h00;
    aluHigh = 8'h00;
    aluC    = 1'b0;
    aluV    = 1'b0;
    sum9    = 9'h000;
    prod    = 16'h0000;
    case (fslQ)
      FSL_ADD: begin
        sum9   = {1'b0, opA} + {1'b0, opB};
        aluLow = sum9[7:0];
        aluC   = sum9[8];
        aluV   = (opA[7] == opB[7]) && (aluLow[7] != opA[7]);
      end
      FSL_SUB, FSL_CMP: begin
        sum9   = {1'b0, opA} - {1'b0, opB};
        aluLow = sum9[7:0];
        aluC   = sum9[8];
        aluV   = (opA[7] != opB[7]) && (aluLow[7] != opA[7]);
      end
      FSL_MUL: begin
        prod    = {8'h00, opA} * {8'h00, opB};
        aluLow  = prod[7:0];
        aluHigh = prod[15:8];
        aluC    = (prod[15:8] != 8'h00);
      end
      FSL_AND:  aluLow = opA & opB;
      FSL_OR:   aluLow = opA | opB;
      FSL_XOR:  aluLow = opA ^ opB;
      FSL_NOT:  aluLow = ~opA;
      FSL_SHL:  begin aluLow = {opA[6:0], 1'b0};    aluC = opA[7]; end
      FSL_SHR:  begin aluLow = {1'b0, opA[7:1]};    aluC = opA[0]; end
      FSL_ROL:  begin aluLow = {opA[6:0], opA[7]};  aluC = opA[7]; end
      FSL_ROR:  begin aluLow = {opA[0], opA[7:1]};  aluC = opA[0]; end
      FSL_INC: begin
        sum9   = {1'b0, opA} + 9'd1;
        aluLow = sum9[7:0];
        aluC   = sum9[8];
        aluV   = (opA == 8'h7F);
      end
      FSL_DEC: begin
        sum9   = {1'b0, opA} - 9'd1;
        aluLow = sum9[7:0];
        aluC   = sum9[8];
        aluV   = (opA == 8'h80);
      end
      FSL_PASS: aluLow = opB;
      FSL_NEG: begin
        sum9   = 9'd0 - {1'b0, opA};
        aluLow = sum9[7:0];
        aluC   = sum9[8];
        aluV   = (opA == 8'h80);
      end
      default: ;
    endcase
  end

  // Load first, ALU writeback after it so writeback wins on the same index.
  always_comb begin
    for (int i = 0; i < 8; i++) regNext[i] = regFile[i];
    if (bus.load && !isBusy) regNext[bus.rc] = bus.ld_data;
    if (isWb && (fslQ != FSL_CMP)) begin
      regNext[rcQ] = aluLow;
`ifdef MUL_HIGH_WB_EN
      if (fslQ == FSL_MUL) regNext[rcQ + 3'd1] = aluHigh;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) regFile[i] <= 8'h00;
    end else begin
      for (int i = 0; i < 8; i++) regFile[i] <= regNext[i];
    end
  end

  // Operands come from regNext so a write landing on the latch edge is seen (write-first).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raQ     <= 3'd0;
      rbQ     <= 3'd0;
      rcQ     <= 3'd0;
      fslQ    <= 4'h0;
      opA     <= 8'h00;
      opB     <= 8'h00;
      resultQ <= 16'h0000;
      sregQ   <= 4'h0;
    end else begin
      if (accept) begin
        raQ  <= bus.ra;
        rbQ  <= bus.rb;
        rcQ  <= bus.rc;
        fslQ <= bus.fsl;
      end
      if (state == S_OPLATCH) begin
        opA <= regNext[raQ];
        opB <= regNext[rbQ];
      end
      if (isWb) begin
        resultQ <= {aluHigh, aluLow};
        sregQ   <= {aluV, aluLow[7], aluC, (aluLow == 8'h00)};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        pcQ <= 8'h00;
    else if (bus.jump) pcQ <= bus.jump_line;
    else if (!bus.hold) pcQ <= pcQ + 8'd1;
  end

  assign bus.rd_a     = regFile[bus.ra];
  assign bus.rd_b     = regFile[bus.rb];
  assign bus.busy     = isBusy;
  assign bus.done     = isWb;
  assign bus.result   = resultQ;
  assign bus.sreg     = sregQ;
  assign bus.pc       = pcQ;
  assign bus.dbgState = state;
endmodule

// File: tb/tb_alu_regfile_pc.sv
// Bench for alu_regfile_pc: directed literal cases plus randomized traffic against an arithmetic reference model.
module tb_alu_regfile_pc;
  logic clk = 1'b0;
  logic rst_n;
  int   nChecks = 0;
  int   nFails  = 0;

  alu_regfile_pc_if bus ();
  alu_regfile_pc dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int          mStage = 0;      // 0 none, 1 operand-latch cycle, 2 writeback cycle
  logic [7:0]  mRegs [8];
  logic [7:0]  mNew  [8];
  logic [2:0]  mRa, mRb, mRc;
  logic [3:0]  mFsl;
  logic [7:0]  mA, mB;
  logic [15:0] mResult = 16'h0;
  logic [3:0]  mSreg = 4'h0;
  logic [7:0]  mPc = 8'h0;
  logic [15:0] mRes;
  logic [3:0]  mFl;

  function automatic void alu_ref(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b,
                                  output logic [15:0] res, output logic [3:0] fl);
    int ua, ub, sa, sb, u, s;
    logic c, v;
    logic [7:0] lo, hi;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    u = 0; s = 0; c = 1'b0; v = 1'b0; hi = 8'h00;
    case (f)
      4'd0:        begin u = ua + ub; s = sa + sb; c = (u > 255); v = (s > 127) || (s < -128); end
      4'd1, 4'd15: begin u = ua - ub; s = sa - sb; c = (ua < ub); v = (s > 127) || (s < -128); end
      4'd2:        begin u = ua * ub; hi = 8'(u / 256); c = (hi != 8'h00); end
      4'd3:        u = ua & ub;
      4'd4:        u = ua | ub;
      4'd5:        u = ua ^ ub;
      4'd6:        u = 255 - ua;
      4'd7:        begin u = ua * 2; c = (ua >= 128); end
      4'd8:        begin u = ua / 2; c = ((ua % 2) != 0); end
      4'd9:        begin u = (ua * 2) % 256 + ua / 128; c = (ua >= 128); end
      4'd10:       begin u = ua / 2 + (ua % 2) * 128; c = ((ua % 2) != 0); end
      4'd11:       begin u = ua + 1; s = sa + 1; c = (u > 255); v = (s > 127); end
      4'd12:       begin u = ua - 1; s = sa - 1; c = (ua == 0); v = (s < -128); end
      4'd13:       u = ub;
      default:     begin u = 0 - ua; s = 0 - sa; c = (ua != 0); v = (s > 127); end
    endcase
    lo  = u[7:0];
    res = {hi, lo};
    fl  = {v, lo[7], c, (lo == 8'h00)};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) mRegs[i] = 8'h00;
      mStage = 0; mResult = 16'h0; mSreg = 4'h0; mPc = 8'h00;
    end else begin
      for (int i = 0; i < 8; i++) mNew[i] = mRegs[i];
      if (bus.load && mStage != 1) mNew[bus.rc] = bus.ld_data;
      if (mStage == 2) begin
        alu_ref(mFsl, mA, mB, mRes, mFl);
        mResult = mRes;
        mSreg   = mFl;
        if (mFsl != 4'd15) begin
          mNew[mRc] = mRes[7:0];
`ifdef MUL_HIGH_WB_EN
          if (mFsl == 4'd2) mNew[(int'(mRc) + 1) % 8] = mRes[15:8];
`endif
        end
      end
      if (mStage == 1) begin
        mA = mNew[mRa];
        mB = mNew[mRb];
        mStage = 2;
      end else if (bus.exec) begin
        mRa = bus.ra; mRb = bus.rb; mRc = bus.rc; mFsl = bus.fsl;
        mStage = 1;
      end else begin
        mStage = 0;
      end
      for (int i = 0; i < 8; i++) mRegs[i] = mNew[i];
      if (bus.jump)       mPc = bus.jump_line;
      else if (!bus.hold) mPc = 8'((int'(mPc) + 1) % 256);
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("busy",   16'(bus.busy),   16'(mStage == 1));
      check("done",   16'(bus.done),   16'(mStage == 2));
      check("result", bus.result,      mResult);
      check("sreg",   16'(bus.sreg),   16'(mSreg));
      check("pc",     16'(bus.pc),     16'(mPc));
      check("rd_a",   16'(bus.rd_a),   16'(mRegs[bus.ra]));
      check("rd_b",   16'(bus.rd_b),   16'(mRegs[bus.rb]));
    end
  end

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_load(input logic [2:0] rc, input logic [7:0] data);
    bus.load = 1'b1; bus.rc = rc; bus.ld_data = data;
    step();
    bus.load = 1'b0;
  endtask

  task automatic do_exec(input logic [3:0] f, input logic [2:0] ra, input logic [2:0] rb, input logic [2:0] rc);
    bus.exec = 1'b1; bus.fsl = f; bus.ra = ra; bus.rb = rb; bus.rc = rc;
    step();
    bus.exec = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.exec = 1'b0; bus.load = 1'b0; bus.ra = 3'd0; bus.rb = 3'd0; bus.rc = 3'd0;
    bus.fsl = 4'h0; bus.ld_data = 8'h00; bus.hold = 1'b0; bus.jump = 1'b0; bus.jump_line = 8'h00;

    @(negedge clk);
    check("rst_pc",     16'(bus.pc),   16'h0000);
    check("rst_busy",   16'(bus.busy), 16'h0000);
    check("rst_done",   16'(bus.done), 16'h0000);
    check("rst_sreg",   16'(bus.sreg), 16'h0000);
    check("rst_result", bus.result,    16'h0000);
    check("rst_r0",     16'(bus.rd_a), 16'h0000);

    step();
    rst_n = 1'b1;
    @(negedge clk); check("pc_seq0", 16'(bus.pc), 16'h0000);
    step(); @(negedge clk); check("pc_seq1", 16'(bus.pc), 16'h0001);
    step(); @(negedge clk); check("pc_seq2", 16'(bus.pc), 16'h0002);

    step();
    bus.jump = 1'b1; bus.jump_line = 8'hF0;
    step();
    bus.jump = 1'b0;
    @(negedge clk); check("pc_jump", 16'(bus.pc), 16'h00F0);
    step();
    bus.jump = 1'b1; bus.jump_line = 8'hFF;
    step();
    bus.jump = 1'b0;
    @(negedge clk); check("pc_ff", 16'(bus.pc), 16'h00FF);
    step(); @(negedge clk); check("pc_wrap", 16'(bus.pc), 16'h0000);

    // ADD 200+100 -> 44 with carry
    step();
    do_load(3'd1, 8'd200);
    do_load(3'd2, 8'd100);
    do_exec(4'h0, 3'd1, 3'd2, 3'd3);
    @(negedge clk); check("add_busy", 16'(bus.busy), 16'h0001);
    step();
    @(negedge clk); check("add_done", 16'(bus.done), 16'h0001);
    step();
    bus.ra = 3'd3;
    @(negedge clk);
    check("add_r3",     16'(bus.rd_a), 16'd44);
    check("add_sreg",   16'(bus.sreg), 16'b0010);
    check("add_result", bus.result,    16'h002C);

    // MUL 15*17 = 255
    step();
    do_load(3'd1, 8'd15);
    do_load(3'd2, 8'd17);
    do_load(3'd5, 8'h55);
    do_exec(4'h2, 3'd1, 3'd2, 3'd4);
    step(); step();
    bus.ra = 3'd4; bus.rb = 3'd5;
    @(negedge clk);
    check("mul_result", bus.result,    16'h00FF);
    check("mul_r4",     16'(bus.rd_a), 16'h00FF);
    check("mul_sreg",   16'(bus.sreg), 16'b0100);
`ifdef MUL_HIGH_WB_EN
    check("mul_r5",     16'(bus.rd_b), 16'h0000);
`else
    check("mul_r5",     16'(bus.rd_b), 16'h0055);
`endif

    // CMP equal operands: flags only
    step();
    do_load(3'd1, 8'd5);
    do_load(3'd2, 8'd5);
    do_load(3'd6, 8'd9);
    do_exec(4'hF, 3'd1, 3'd2, 3'd6);
    step(); step();
    bus.ra = 3'd6;
    @(negedge clk);
    check("cmp_sreg",   16'(bus.sreg), 16'b0001);
    check("cmp_r6",     16'(bus.rd_a), 16'd9);
    check("cmp_result", bus.result,    16'h0000);

    // INC 127 -> 128 overflows
    step();
    do_load(3'd7, 8'd127);
    do_exec(4'hB, 3'd7, 3'd0, 3'd7);
    step(); step();
    bus.ra = 3'd7;
    @(negedge clk);
    check("inc_r7",   16'(bus.rd_a), 16'd128);
    check("inc_sreg", 16'(bus.sreg), 16'b1100);

    // exec while busy is dropped
    step();
    do_exec(4'h0, 3'd1, 3'd2, 3'd3);
    bus.exec = 1'b1; bus.fsl = 4'hD; bus.ra = 3'd0; bus.rb = 3'd1; bus.rc = 3'd0;
    step();
    bus.exec = 1'b0;
    @(negedge clk); check("ign_done", 16'(bus.done), 16'h0001);
    step();
    bus.ra = 3'd0; bus.rb = 3'd3;
    @(negedge clk);
    check("ign_r0",   16'(bus.rd_a), 16'h0000);
    check("ign_r3",   16'(bus.rd_b), 16'd10);
    check("ign_busy", 16'(bus.busy), 16'h0000);

    // reset during the operand cycle aborts the op
    step();
    do_exec(4'h0, 3'd1, 3'd2, 3'd5);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", 16'(bus.busy), 16'h0000);
    check("abort_pc",   16'(bus.pc),   16'h0000);
    check("abort_sreg", 16'(bus.sreg), 16'h0000);
    step(); step();
    rst_n = 1'b1;
    @(negedge clk); check("abort_done0", 16'(bus.done), 16'h0000);
    step();
    bus.ra = 3'd5;
    @(negedge clk);
    check("abort_done1", 16'(bus.done), 16'h0000);
    check("abort_r5",    16'(bus.rd_a), 16'h0000);

    // randomized traffic, model-checked every cycle
    step();
    for (int k = 0; k < 600; k++) begin
      bus.exec      = ($urandom_range(0, 2) == 0);
      bus.load      = ($urandom_range(0, 2) == 0);
      bus.ra        = 3'($urandom_range(0, 7));
      bus.rb        = 3'($urandom_range(0, 7));
      bus.rc        = 3'($urandom_range(0, 7));
      bus.fsl       = 4'($urandom_range(0, 15));
      bus.ld_data   = 8'($urandom);
      bus.hold      = ($urandom_range(0, 3) == 0);
      bus.jump      = ($urandom_range(0, 15) == 0);
      bus.jump_line = 8'($urandom);
      step();
    end
    bus.exec = 1'b0; bus.load = 1'b0; bus.jump = 1'b0;
    step(); step(); step();
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end
endmodule
